// File: rtl/i2c_reg_bank_if.sv
// Byte-level user interface between the I2C slave engine and a register bank.
// The "master" side is the slave engine; the "slave" side is the register bank.
interface i2c_reg_bank_if;
   logic       read_req;
   logic       data_valid;
   logic [7:0] data_from_master;
   logic [7:0] write_cycle_count;
   logic [7:0] data_to_master;

   modport master (output read_req, data_valid, data_from_master, write_cycle_count,
                   input  data_to_master);
   modport slave  (input  read_req, data_valid, data_from_master, write_cycle_count,
                   output data_to_master);
endinterface

// File: rtl/i2c_reg_bank.sv
// Byte-addressed register bank behind an I2C slave: pointer byte then auto-increment.
// Low registers are RW control exported to fabric; high registers read back status_in.
module i2c_reg_bank #(
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4,
   parameter int RW_REGS  = 8,
   parameter logic [RW_REGS*8-1:0] CTRL_INIT = '0
) (
   input  logic                clk,
   input  logic                rst,
   i2c_reg_bank_if.slave       bus,
   input  logic                loc_we,
   input  logic [ADDR_W-1:0]   loc_addr,
   input  logic [7:0]          loc_data,
   input  logic [((NUM_REGS>RW_REGS)?(NUM_REGS-RW_REGS):1)*8-1:0] status_in,
   output logic [RW_REGS*8-1:0] ctrl_regs,
   output logic [NUM_REGS-1:0] wr_strobe,
   output logic [ADDR_W-1:0]   reg_ptr
);

   logic [RW_REGS*8-1:0] ctrl_q;
   logic [NUM_REGS-1:0][7:0] all_regs;
   logic ptr_wr, data_wr;

   // data_valid outranks read_req if both ever arrive together
   assign ptr_wr  = bus.data_valid && (bus.write_cycle_count == 8'd1);
   assign data_wr = bus.data_valid && (bus.write_cycle_count != 8'd1);

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_map
      if (g < RW_REGS) begin : g_rw
         assign all_regs[g] = ctrl_q[8*g +: 8];
      end else begin : g_ro
         assign all_regs[g] = status_in[8*(g-RW_REGS) +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_ptr            <= '0;
         ctrl_q             <= CTRL_INIT;
         wr_strobe          <= '0;
         bus.data_to_master <= CTRL_INIT[7:0];
      end else begin
         wr_strobe          <= data_wr ? (NUM_REGS'(1) << reg_ptr) : '0;
         bus.data_to_master <= all_regs[reg_ptr];

         if (ptr_wr)
            reg_ptr <= bus.data_from_master[ADDR_W-1:0];
         else if (data_wr || bus.read_req)
            reg_ptr <= reg_ptr + ADDR_W'(1);

         // I2C write checked first so it wins a same-register collision
         for (int n = 0; n < RW_REGS; n++) begin
            if (data_wr && reg_ptr == ADDR_W'(n))
               ctrl_q[8*n +: 8] <= bus.data_from_master;
            else if (loc_we && loc_addr == ADDR_W'(n))
               ctrl_q[8*n +: 8] <= loc_data;
         end
      end
   end

   assign ctrl_regs = ctrl_q;

endmodule
